// File: rtl/counter_pkg.sv
// Shared constants and helpers for the synchronous modulus counter family.
//   DIR_UP / DIR_DN     : values of the UP_DN direction input.
//   MODE_WRAP / MODE_SAT: values of the SATURATE parameter.
//   params_legal()      : elaboration-time range check for WIDTH/MOD/SATURATE.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // WIDTH in 1..32, MOD in 2..2**WIDTH, SATURATE is 0 or 1.
  function automatic bit params_legal(input int unsigned     width,
                                      input longint unsigned mod,
                                      input int unsigned     sat);
    bit ok;
    ok = 1'b1;
    if (width < 1 || width > 32) ok = 1'b0;
    if (ok && (mod < 64'd2 || mod > (64'd1 << width))) ok = 1'b0;
    if (sat > MODE_SAT) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/sync_mod_counter_next.sv
// Combinational next-state and terminal-count function of the modulus counter.
// Holds no state so several channels can share the same logic shape.
//   q_i      : current count
//   up_dn_i  : direction (DIR_UP / DIR_DN)
//   en_i     : count enable
//   load_i   : parallel load (wins over counting)
//   d_i      : load value, clamped to MOD-1
//   q_next_o : next count, excluding reset
//   tc_o     : terminal count for the current direction, not gated by enable
module sync_mod_counter_next
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 3,
  parameter longint unsigned MOD      = 8,
  parameter int unsigned     SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             up_dn_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_next_o,
  output logic             tc_o
);

  // Terminal value as a WIDTH-bit constant; for MOD == 2**WIDTH this is all ones.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD - 64'd1);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic at_max;
  logic at_zero;

  always_comb begin
    at_max  = (q_i == MaxVal);
    at_zero = (q_i == '0);
    tc_o    = (up_dn_i == DIR_UP) ? at_max : at_zero;

    q_next_o = q_i;
    if (load_i) begin
      // Clamp so the register never holds an out-of-range state.
      q_next_o = (d_i > MaxVal) ? MaxVal : d_i;
    end else if (en_i) begin
      if (up_dn_i == DIR_UP) begin
        if (at_max) q_next_o = (SATURATE == MODE_SAT) ? q_i : '0;
        else        q_next_o = q_i + One;
      end else begin
        if (at_zero) q_next_o = (SATURATE == MODE_SAT) ? q_i : MaxVal;
        else         q_next_o = q_i - One;
      end
    end
  end

endmodule

// File: rtl/sync_mod_counter.sv
// Parametrised synchronous modulus counter with up/down, load, enable and
// optional saturation. Registers update on the falling edge of CLK.
//   CLK   : clock (falling edge active)
//   RST   : synchronous active-high reset, Q <= 0
//   EN    : count enable
//   UP_DN : direction, 1 = up, 0 = down
//   LOAD  : synchronous parallel load of D (clamped to MOD-1)
//   D     : load value
//   Q     : registered count
//   TC    : terminal count (Q == MOD-1 going up, Q == 0 going down)
//   CO    : cascade carry/borrow out, TC & EN
module sync_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 3,
  parameter longint unsigned MOD      = 8,
  parameter int unsigned     SATURATE = MODE_WRAP
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             UP_DN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CO
);

  if (!params_legal(WIDTH, MOD, SATURATE)) begin : g_bad_params
    $error("sync_mod_counter: illegal WIDTH/MOD/SATURATE combination");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_next;
  logic             tc;

  sync_mod_counter_next #(
    .WIDTH    (WIDTH),
    .MOD      (MOD),
    .SATURATE (SATURATE)
  ) u_next (
    .q_i      (q_q),
    .up_dn_i  (UP_DN),
    .en_i     (EN),
    .load_i   (LOAD),
    .d_i      (D),
    .q_next_o (q_next),
    .tc_o     (tc)
  );

  // Reset overrides load and count.
  always_comb begin
    q_d = RST ? '0 : q_next;
  end

  always_ff @(negedge CLK) begin
    q_q <= q_d;
  end

  assign Q  = q_q;
  assign TC = tc;
  assign CO = tc & EN;

endmodule

// File: tb/tb_sync_mod_counter.sv
// Directed bench for sync_mod_counter: a 3-bit mod-8 wrapping counter, a
// two-stage BCD cascade of mod-10 wrapping counters, and a mod-10 saturating counter.
module tb_sync_mod_counter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: WIDTH=3, MOD=8, wrap.
  logic       rst_a = 1'b1, en_a = 1'b0, up_a = 1'b0, load_a = 1'b0;
  logic [2:0] d_a = '0, q_a;
  logic       tc_a, co_a;

  // Instance B (low BCD digit) and H (high BCD digit): WIDTH=4, MOD=10, wrap.
  logic       rst_b = 1'b1, en_b = 1'b0, up_b = 1'b0, load_b = 1'b0;
  logic [3:0] d_b = '0, q_b, q_h;
  logic       tc_b, co_b, tc_h, co_h;

  // Instance C: WIDTH=4, MOD=10, saturating.
  logic       rst_c = 1'b1, en_c = 1'b0, up_c = 1'b0, load_c = 1'b0;
  logic [3:0] d_c = '0, q_c;
  logic       tc_c, co_c;

  sync_mod_counter #(.WIDTH(3), .MOD(8), .SATURATE(0)) u_a (
    .CLK(CLK), .RST(rst_a), .EN(en_a), .UP_DN(up_a), .LOAD(load_a), .D(d_a),
    .Q(q_a), .TC(tc_a), .CO(co_a)
  );

  sync_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(0)) u_b (
    .CLK(CLK), .RST(rst_b), .EN(en_b), .UP_DN(up_b), .LOAD(load_b), .D(d_b),
    .Q(q_b), .TC(tc_b), .CO(co_b)
  );

  sync_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(0)) u_h (
    .CLK(CLK), .RST(rst_b), .EN(co_b), .UP_DN(up_b), .LOAD(1'b0), .D(4'd0),
    .Q(q_h), .TC(tc_h), .CO(co_h)
  );

  sync_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(1)) u_c (
    .CLK(CLK), .RST(rst_c), .EN(en_c), .UP_DN(up_c), .LOAD(load_c), .D(d_c),
    .Q(q_c), .TC(tc_c), .CO(co_c)
  );

  // Inputs change just after the rising edge, outputs are sampled just after
  // the falling (active) edge.
  task automatic drive_slot();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic test_reset();
    drive_slot();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick();
    n_checks++;
    if (q_a !== 3'd0) begin n_errors++; $display("FAIL reset_q_a: got %0d expected 0", q_a); end
    n_checks++;
    if (q_b !== 4'd0 || q_h !== 4'd0) begin
      n_errors++; $display("FAIL reset_q_bcd: got %0d/%0d expected 0/0", q_h, q_b);
    end
    n_checks++;
    if (q_c !== 4'd0) begin n_errors++; $display("FAIL reset_q_c: got %0d expected 0", q_c); end
    // Down direction at Q=0 is terminal; EN=0 keeps CO low.
    n_checks++;
    if (tc_a !== 1'b1 || co_a !== 1'b0) begin
      n_errors++; $display("FAIL reset_tc_co: got tc=%b co=%b expected tc=1 co=0", tc_a, co_a);
    end
    drive_slot();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
  endtask

  task automatic test_up_wrap();
    int exp;
    drive_slot();
    en_a = 1'b1; up_a = 1'b1;
    #1;
    n_checks++;
    if (tc_a !== 1'b0) begin n_errors++; $display("FAIL up_tc_at0: got %b expected 0", tc_a); end
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp = i % 8;
      n_checks++;
      if (q_a !== 3'(exp) || tc_a !== (exp == 7) || co_a !== (exp == 7)) begin
        n_errors++;
        $display("FAIL up_wrap[%0d]: got q=%0d tc=%b co=%b expected q=%0d tc=co=%b",
                 i, q_a, tc_a, co_a, exp, exp == 7);
      end
    end
  endtask

  task automatic test_reverse();
    drive_slot();
    load_a = 1'b1; d_a = 3'd5; en_a = 1'b0;
    tick();
    drive_slot();
    load_a = 1'b0; en_a = 1'b1; up_a = 1'b1;
    tick();
    n_checks++;
    if (q_a !== 3'd6) begin n_errors++; $display("FAIL reverse_up: got %0d expected 6", q_a); end
    drive_slot();
    up_a = 1'b0;
    tick();
    n_checks++;
    if (q_a !== 3'd5) begin n_errors++; $display("FAIL reverse_dn: got %0d expected 5", q_a); end
    drive_slot();
    en_a = 1'b0;
  endtask

  task automatic test_down_wrap();
    int exp;
    drive_slot();
    rst_b = 1'b1;
    tick();
    drive_slot();
    rst_b = 1'b0; en_b = 1'b1; up_b = 1'b0;
    #1;
    n_checks++;
    if (tc_b !== 1'b1 || co_b !== 1'b1) begin
      n_errors++; $display("FAIL down_tc_at0: got tc=%b co=%b expected 1 1", tc_b, co_b);
    end
    for (int i = 1; i <= 11; i++) begin
      tick();
      exp = (10 - (i % 10)) % 10;
      n_checks++;
      if (q_b !== 4'(exp) || tc_b !== (exp == 0)) begin
        n_errors++;
        $display("FAIL down_wrap[%0d]: got q=%0d tc=%b expected q=%0d tc=%b",
                 i, q_b, tc_b, exp, exp == 0);
      end
    end
  endtask

  task automatic test_cascade();
    int exp_lo, exp_hi;
    drive_slot();
    rst_b = 1'b1;
    tick();
    drive_slot();
    rst_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      if (i == 100) begin
        // Lo=9, Hi=9: both stages are terminal, so the high carry fires.
        n_checks++;
        if (co_h !== 1'b1) begin n_errors++; $display("FAIL cascade_co_h99: got %b expected 1", co_h); end
      end
      tick();
      exp_lo = i % 10;
      exp_hi = (i / 10) % 10;
      n_checks++;
      if (q_b !== 4'(exp_lo) || q_h !== 4'(exp_hi)) begin
        n_errors++;
        $display("FAIL cascade[%0d]: got %0d%0d expected %0d%0d", i, q_h, q_b, exp_hi, exp_lo);
      end
    end
    drive_slot();
    en_b = 1'b0;
  endtask

  task automatic test_saturate();
    logic [3:0] exp_q [4] = '{4'd8, 4'd9, 4'd9, 4'd9};
    logic       exp_tc[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    drive_slot();
    load_c = 1'b1; d_c = 4'd7;
    tick();
    n_checks++;
    if (q_c !== 4'd7) begin n_errors++; $display("FAIL sat_load7: got %0d expected 7", q_c); end
    drive_slot();
    load_c = 1'b0; en_c = 1'b1; up_c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (q_c !== exp_q[i] || tc_c !== exp_tc[i] || co_c !== exp_tc[i]) begin
        n_errors++;
        $display("FAIL sat_up[%0d]: got q=%0d tc=%b co=%b expected q=%0d tc=co=%b",
                 i, q_c, tc_c, co_c, exp_q[i], exp_tc[i]);
      end
    end
    drive_slot();
    up_c = 1'b0;
    #1;
    n_checks++;
    if (tc_c !== 1'b0) begin n_errors++; $display("FAIL sat_tc_dir: got %b expected 0", tc_c); end
    tick();
    n_checks++;
    if (q_c !== 4'd8) begin n_errors++; $display("FAIL sat_reverse: got %0d expected 8", q_c); end
    drive_slot();
    load_c = 1'b1; d_c = 4'd0;
    tick();
    drive_slot();
    load_c = 1'b0;
    tick();
    n_checks++;
    if (q_c !== 4'd0 || tc_c !== 1'b1) begin
      n_errors++; $display("FAIL sat_hold0: got q=%0d tc=%b expected q=0 tc=1", q_c, tc_c);
    end
    drive_slot();
    en_c = 1'b0;
  endtask

  task automatic test_load();
    logic [3:0] d_vec [6] = '{4'd12, 4'd3, 4'd10, 4'd15, 4'd9, 4'd5};
    logic       en_vec[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] q_vec [6] = '{4'd9, 4'd3, 4'd9, 4'd9, 4'd9, 4'd5};
    for (int i = 0; i < 6; i++) begin
      drive_slot();
      load_b = 1'b1; d_b = d_vec[i]; en_b = en_vec[i]; up_b = 1'b1;
      tick();
      n_checks++;
      if (q_b !== q_vec[i]) begin
        n_errors++; $display("FAIL load[%0d]: got %0d expected %0d", i, q_b, q_vec[i]);
      end
    end
    drive_slot();
    load_b = 1'b0;
    tick();
    n_checks++;
    if (q_b !== 4'd6) begin n_errors++; $display("FAIL load_resume: got %0d expected 6", q_b); end
  endtask

  task automatic test_back_to_back();
    // Q=6 from test_load, still counting up.
    drive_slot();
    rst_b = 1'b1; load_b = 1'b1; d_b = 4'd2;
    tick();
    n_checks++;
    if (q_b !== 4'd0) begin n_errors++; $display("FAIL rst_over_load: got %0d expected 0", q_b); end
    drive_slot();
    rst_b = 1'b0; load_b = 1'b0;
    tick();
    n_checks++;
    if (q_b !== 4'd1) begin n_errors++; $display("FAIL rst_resume: got %0d expected 1", q_b); end
    drive_slot();
    load_b = 1'b1; d_b = 4'd9; en_b = 1'b0;
    tick();
    drive_slot();
    load_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (q_b !== 4'd9 || tc_b !== 1'b1 || co_b !== 1'b0) begin
        n_errors++;
        $display("FAIL hold[%0d]: got q=%0d tc=%b co=%b expected q=9 tc=1 co=0",
                 i, q_b, tc_b, co_b);
      end
    end
    drive_slot();
    en_b = 1'b1;
    #1;
    n_checks++;
    if (co_b !== 1'b1) begin n_errors++; $display("FAIL co_en: got %b expected 1", co_b); end
    tick();
    n_checks++;
    if (q_b !== 4'd0) begin n_errors++; $display("FAIL hold_wrap: got %0d expected 0", q_b); end
    drive_slot();
    en_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_reverse();
    test_down_wrap();
    test_cascade();
    test_saturate();
    test_load();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
